// File: rtl/rf_read_arbiter_pkg.sv
// Package: rf_read_arbiter_pkg
// Purpose: shared types and constants for the register-file read-port arbiter.
//   - mem_read_req_t / mem_read_rsp_t : one regfile read port request/response
//   - rfa_state_t                     : arbiter FSM states
//   - RF_READ_PORTS                   : number of regfile read ports (rs1, rs2)
//   - has_active_port()               : helper, true when either port of a requester is enabled
package rf_read_arbiter_pkg;

  localparam int RF_READ_PORTS = 2;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_DATA_W     = 32;
  localparam int RF_MASK_W     = 4;

  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_MASK_W-1:0] mask;
  } mem_read_req_t;

  typedef struct packed {
    logic                 done;
    logic                 valid;
    logic [RF_DATA_W-1:0] data;
  } mem_read_rsp_t;

  typedef enum logic {RFA_IDLE, RFA_BUSY} rfa_state_t;

  function automatic logic has_active_port(input mem_read_req_t rs1, input mem_read_req_t rs2);
    return rs1.en | rs2.en;
  endfunction

endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Module: rr_pick
// Purpose: combinational round-robin picker. Finds the first set bit of 'active'
//   at or after 'start', wrapping modulo N. Also intended for the write-port arbiter.
// Ports:
//   active  in  N      request vector
//   start   in  IDX_W  index with highest priority
//   found   out 1      at least one bit of 'active' is set
//   idx     out IDX_W  chosen index (0 when nothing found)
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     active,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to 'start' so the last hit written is
  // the nearest one, which gives the round-robin priority without a break.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(start) + i) % N);
      if (active[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Module: rf_read_arbiter
// Purpose: shares the regfile's two read ports between NUM_REQ decode requesters.
//   The owner gets both ports together, so its rs1/rs2 pair is read atomically.
//   Grants are round-robin and each grant is held until every enabled port reports done.
// Ports:
//   clk       in   1                      clock
//   rst       in   1                      synchronous active-high reset
//   req_i     in   [NUM_REQ][2] requests  per-requester rs1/rs2 read requests
//   rsp_o     out  [NUM_REQ][2] responses per-requester responses
//   rf_req_o  out  [2] requests           registered requests to regfile ports 0/1
//   rf_rsp_i  in   [2] responses          responses from regfile ports 0/1
//   gnt_o     out  NUM_REQ                one-hot current owner, zero when idle
//   busy_o    out  1                      a transaction is in progress
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  mem_read_req_t req_i    [NUM_REQ][RF_READ_PORTS],
  output mem_read_rsp_t rsp_o    [NUM_REQ][RF_READ_PORTS],
  output mem_read_req_t rf_req_o [RF_READ_PORTS],
  input  mem_read_rsp_t rf_rsp_i [RF_READ_PORTS],
  output logic [NUM_REQ-1:0] gnt_o,
  output logic          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  rfa_state_t          state, next_state;
  logic [IDX_W-1:0]    rr_ptr, owner, pick_idx, rr_next;
  logic [NUM_REQ-1:0]  active, gnt;
  logic                pick_found;
  mem_read_req_t       latched [RF_READ_PORTS];
  logic [RF_READ_PORTS-1:0] port_done;
  logic                all_done;

  always_comb begin
    active = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      active[r] = has_active_port(req_i[r][0], req_i[r][1]);
    end
  end

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .active(active),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A port that was never enabled counts as already done.
  always_comb begin
    port_done = '0;
    for (int p = 0; p < RF_READ_PORTS; p++) begin
      port_done[p] = !latched[p].en | rf_rsp_i[p].done;
    end
    all_done = &port_done;
    rr_next  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      RFA_IDLE: if (pick_found) next_state = RFA_BUSY;
      RFA_BUSY: if (all_done)   next_state = RFA_IDLE;
      default:  next_state = RFA_IDLE;
    endcase
  end

  // The requests are copied at grant time so the regfile sees a stable request
  // even if the owner changes or drops req_i during the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RFA_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      gnt    <= '0;
      for (int p = 0; p < RF_READ_PORTS; p++) begin
        latched[p] <= '0;
      end
    end else begin
      state <= next_state;
      case (state)
        RFA_IDLE: begin
          if (pick_found) begin
            owner  <= pick_idx;
            gnt    <= NUM_REQ'(1) << pick_idx;
            rr_ptr <= rr_next;
            for (int p = 0; p < RF_READ_PORTS; p++) begin
              latched[p] <= req_i[pick_idx][p];
            end
          end
        end
        RFA_BUSY: begin
          if (all_done) begin
            gnt <= '0;
            for (int p = 0; p < RF_READ_PORTS; p++) begin
              latched[p].en <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_req_o = latched;
  assign gnt_o    = gnt;
  assign busy_o   = (state == RFA_BUSY);

  // Only the owner sees regfile responses; a port it did not enable reports an
  // immediate, data-less done so the requester can treat both ports uniformly.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int p = 0; p < RF_READ_PORTS; p++) begin
        rsp_o[r][p] = '0;
        if (state == RFA_BUSY && IDX_W'(r) == owner) begin
          if (latched[p].en) begin
            rsp_o[r][p] = rf_rsp_i[p];
          end else begin
            rsp_o[r][p].done = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Testbench: tb_rf_read_arbiter
// Purpose: drives a cycle-by-cycle table of requester and regfile inputs into
//   rf_read_arbiter (NUM_REQ=2) and compares grant, busy, regfile requests and
//   routed responses against hand-computed values for each cycle.
module tb_rf_read_arbiter;
  import rf_read_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic          clk;
  logic          rst;
  mem_read_req_t req      [NREQ][RF_READ_PORTS];
  mem_read_rsp_t rsp      [NREQ][RF_READ_PORTS];
  mem_read_req_t rf_req   [RF_READ_PORTS];
  mem_read_rsp_t rf_rsp   [RF_READ_PORTS];
  logic [NREQ-1:0] gnt;
  logic          busy;

  int num_vectors;
  int num_miscompares;

  typedef struct {
    logic        rst;
    logic [1:0]  en0;
    logic [4:0]  a00, a01;
    logic [1:0]  en1;
    logic [4:0]  a10, a11;
    logic [1:0]  rdone, rvalid;
    logic [31:0] rd0, rd1;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [1:0]  e_rfen;
    logic [4:0]  e_rfa0, e_rfa1;
    logic [1:0]  e_r0dn, e_r0vl;
    logic [31:0] e_r0d0, e_r0d1;
    logic [1:0]  e_r1dn, e_r1vl;
    logic [31:0] e_r1d0, e_r1d1;
  } vec_t;

  vec_t vecs[$];

  rf_read_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .rsp_o   (rsp),
    .rf_req_o(rf_req),
    .rf_rsp_i(rf_rsp),
    .gnt_o   (gnt),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Columns: inputs (rst, en0, a00, a01, en1, a10, a11, rf done, rf valid, rf data0, rf data1)
  // then expected (gnt, busy, rf en, rf addr0, rf addr1,
  //                req0 done, req0 valid, req0 data0, req0 data1,
  //                req1 done, req1 valid, req1 data0, req1 data1).
  // Two-bit fields hold port 1 in bit 1 and port 0 in bit 0.
  function automatic vec_t mk(
    input int rst_v, en0, a00, a01, en1, a10, a11, rdone, rvalid, rd0, rd1,
    input int e_gnt, e_busy, e_rfen, e_rfa0, e_rfa1,
    input int e_r0dn, e_r0vl, e_r0d0, e_r0d1, e_r1dn, e_r1vl, e_r1d0, e_r1d1);
    vec_t v;
    v.rst    = 1'(rst_v);
    v.en0    = 2'(en0);   v.a00 = 5'(a00); v.a01 = 5'(a01);
    v.en1    = 2'(en1);   v.a10 = 5'(a10); v.a11 = 5'(a11);
    v.rdone  = 2'(rdone); v.rvalid = 2'(rvalid);
    v.rd0    = 32'(rd0);  v.rd1 = 32'(rd1);
    v.e_gnt  = 2'(e_gnt); v.e_busy = 1'(e_busy); v.e_rfen = 2'(e_rfen);
    v.e_rfa0 = 5'(e_rfa0); v.e_rfa1 = 5'(e_rfa1);
    v.e_r0dn = 2'(e_r0dn); v.e_r0vl = 2'(e_r0vl);
    v.e_r0d0 = 32'(e_r0d0); v.e_r0d1 = 32'(e_r0d1);
    v.e_r1dn = 2'(e_r1dn); v.e_r1vl = 2'(e_r1vl);
    v.e_r1d0 = 32'(e_r1d0); v.e_r1d1 = 32'(e_r1d1);
    return v;
  endfunction

  task automatic cmp(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      num_miscompares++;
      $display("[TB] FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    for (int p = 0; p < RF_READ_PORTS; p++) begin
      req[0][p].en   = v.en0[p];
      req[1][p].en   = v.en1[p];
      req[0][p].mask = 4'hA;
      req[1][p].mask = 4'hA;
      rf_rsp[p].done  = v.rdone[p];
      rf_rsp[p].valid = v.rvalid[p];
    end
    req[0][0].addr = v.a00; req[0][1].addr = v.a01;
    req[1][0].addr = v.a10; req[1][1].addr = v.a11;
    rf_rsp[0].data = v.rd0; rf_rsp[1].data = v.rd1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    num_vectors++;
    cmp(idx, "gnt",      32'(gnt), 32'(v.e_gnt));
    cmp(idx, "busy",     32'(busy), 32'(v.e_busy));
    cmp(idx, "rf_en",    32'({rf_req[1].en, rf_req[0].en}), 32'(v.e_rfen));
    cmp(idx, "rf_addr0", 32'(rf_req[0].addr), 32'(v.e_rfa0));
    cmp(idx, "rf_addr1", 32'(rf_req[1].addr), 32'(v.e_rfa1));
    cmp(idx, "r0_done",  32'({rsp[0][1].done, rsp[0][0].done}), 32'(v.e_r0dn));
    cmp(idx, "r0_valid", 32'({rsp[0][1].valid, rsp[0][0].valid}), 32'(v.e_r0vl));
    cmp(idx, "r0_data0", rsp[0][0].data, v.e_r0d0);
    cmp(idx, "r0_data1", rsp[0][1].data, v.e_r0d1);
    cmp(idx, "r1_done",  32'({rsp[1][1].done, rsp[1][0].done}), 32'(v.e_r1dn));
    cmp(idx, "r1_valid", 32'({rsp[1][1].valid, rsp[1][0].valid}), 32'(v.e_r1vl));
    cmp(idx, "r1_data0", rsp[1][0].data, v.e_r1d0);
    cmp(idx, "r1_data1", rsp[1][1].data, v.e_r1d1);
  endtask

  initial begin
    num_vectors     = 0;
    num_miscompares = 0;

    // Idle after reset.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));
    // Single request rs1=5 rs2=7, one-cycle regfile.
    vecs.push_back(mk(0,3,5,7,0,0,0,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,5,7,0,0,0,3,3,'hA5,'hA7,    1,1,3,5,7, 3,3,'hA5,'hA7,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,          0,0,0,5,7, 0,0,0,0,0,0,0,0));
    // Both active, three-cycle regfile: grants alternate 1,0,1.
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          0,0,0,5,7, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          2,1,3,3,4, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          2,1,3,3,4, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,3,3,'h31,'h41,    2,1,3,3,4, 0,0,0,0,3,3,'h31,'h41));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          0,0,0,3,4, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          1,1,3,1,2, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          1,1,3,1,2, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,3,3,'h11,'h21,    1,1,3,1,2, 3,3,'h11,'h21,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          0,0,0,1,2, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,3,3,'h32,'h42,    2,1,3,3,4, 0,0,0,0,3,3,'h32,'h42));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,          0,0,0,3,4, 0,0,0,0,0,0,0,0));
    // Requester 1 with rs1 only; disabled port done at once with zero data.
    vecs.push_back(mk(0,0,0,0,1,9,10,0,0,0,0,         0,0,0,3,4, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,2,0,'hDEAD,     2,1,1,9,10, 0,0,0,0,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,3,'h99,'hDEAD,  2,1,1,9,10, 0,0,0,0,3,1,'h99,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,          0,0,0,9,10, 0,0,0,0,0,0,0,0));
    // Owner changes addr and drops en while busy; next grant goes to requester 1.
    vecs.push_back(mk(0,3,12,13,3,14,15,0,0,0,0,      0,0,0,9,10, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,20,21,3,14,15,0,0,0,0,      1,1,3,12,13, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,20,21,3,14,15,3,3,'h55,'h66, 1,1,3,12,13, 3,3,'h55,'h66,0,0,0,0));
    vecs.push_back(mk(0,0,20,21,3,14,15,0,0,0,0,      0,0,0,12,13, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,3,3,'h88,'h89,    2,1,3,14,15, 0,0,0,0,3,3,'h88,'h89));
    // Reset while busy with rr_ptr=1, then a stray done, then rr_ptr restarts at 0.
    vecs.push_back(mk(0,3,16,17,0,0,0,0,0,0,0,        0,0,0,14,15, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,          1,1,3,16,17, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,3,3,'h77,'h78,    0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,3,1,2,3,3,4,0,0,0,0,          0,0,0,0,0, 0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,3,3,'h11,'h21,    1,1,3,1,2, 3,3,'h11,'h21,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,          0,0,0,1,2, 0,0,0,0,0,0,0,0));

    // Reset sequence with all inputs quiet.
    applyStimulus(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    num_vectors++;
    cmp(-1, "reset_mask0", 32'(rf_req[0].mask), 32'h0);
    cmp(-1, "reset_mask1", 32'(rf_req[1].mask), 32'h0);
    cmp(-1, "reset_busy",  32'(busy), 32'h0);
    cmp(-1, "reset_gnt",   32'(gnt), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    // The mask of the last grant is still held in the regfile request register.
    num_vectors++;
    cmp(-2, "latched_mask", 32'(rf_req[0].mask), 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
